// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - states and table markers shared by the OV7670 register loader
package ov7670_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_READY,
    WAIT_ACCEPT,
    WAIT_DONE,
    DELAY,
    FINISH
  } cfg_state_e;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARKER = 16'hFFF0;
  localparam logic [15:0] RESET_ENTRY  = 16'h1280;

endpackage

// File: rtl/ov7670_config_rom.sv
// rtl/ov7670_config_rom.sv - OV7670 init table, {reg address, reg value}, one-cycle read
module ov7670_config_rom
  import ov7670_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [15:0]       entry
);

  logic [15:0] entry_c;

  // COM7 soft reset needs settling time before any further register writes
  always_comb begin
    entry_c = END_MARKER;
    case (int'(addr))
      0:       entry_c = RESET_ENTRY;
      1:       entry_c = DELAY_MARKER;
      2:       entry_c = 16'h1104;
      3:       entry_c = 16'h1204;
      4:       entry_c = 16'h40D0;
      5:       entry_c = 16'h3A04;
      6:       entry_c = 16'h8C00;
      default: entry_c = END_MARKER;
    endcase
  end

  always_ff @(posedge clk) begin
    entry <= entry_c;
  end

endmodule

// File: rtl/ov7670_config.sv
// rtl/ov7670_config.sv - walks the init table and issues SCCB register writes with delays and timeout
module ov7670_config
  import ov7670_pkg::*;
#(
  parameter int DELAY_CYCLES   = 100000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ROM_DEPTH      = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       config_start,
  input  logic       sccb_ready,
  input  logic       sccb_done,
  output logic       sccb_start,
  output logic [7:0] sccb_sub_address,
  output logic [7:0] sccb_data,
  output logic       config_busy,
  output logic       config_done,
  output logic       config_error
);

  localparam int              IDX_W        = $clog2(ROM_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(ROM_DEPTH - 1);
  localparam logic [31:0]     DELAY_LAST   = 32'(DELAY_CYCLES - 1);
  localparam logic [31:0]     TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  cfg_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             start_q, start_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      rom_entry;
  logic             timeout_hit;

  // ROM is addressed with the next index so its output is valid during FETCH
  ov7670_config_rom #(.ADDR_W(IDX_W)) u_rom (
    .clk   (clk),
    .addr  (idx_d),
    .entry (rom_entry)
  );

  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (config_start) begin
        idx_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = FETCH;
      end
      FETCH: begin
        if (rom_entry == END_MARKER || idx_q == LAST_IDX) begin
          state_d = FINISH;
        end else if (rom_entry == DELAY_MARKER) begin
          cnt_d   = '0;
          state_d = DELAY;
        end else begin
          addr_d  = rom_entry[15:8];
          data_d  = rom_entry[7:0];
          state_d = WAIT_READY;
        end
      end
      WAIT_READY: if (sccb_ready) begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!sccb_ready) begin
          start_d = 1'b0;
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (timeout_hit) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (sccb_done) begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end else if (timeout_hit) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sccb_start       = start_q;
  assign sccb_sub_address = addr_q;
  assign sccb_data        = data_q;
  assign config_busy      = busy_q;
  assign config_done      = done_q;
  assign config_error     = err_q;

endmodule

// File: tb/tb_ov7670_config.sv
// tb/tb_ov7670_config.sv - randomized bench for ov7670_config against a table-walk reference model
module tb_ov7670_config;

  localparam int DLY   = 50;
  localparam int TMO   = 100;
  localparam int DEPTH = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       config_start = 1'b0;
  logic       sccb_ready = 1'b0;
  logic       sccb_done = 1'b0;
  logic       sccb_start;
  logic [7:0] sccb_sub_address;
  logic [7:0] sccb_data;
  logic       config_busy;
  logic       config_done;
  logic       config_error;

  ov7670_config #(.DELAY_CYCLES(DLY), .TIMEOUT_CYCLES(TMO), .ROM_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .config_start     (config_start),
    .sccb_ready       (sccb_ready),
    .sccb_done        (sccb_done),
    .sccb_start       (sccb_start),
    .sccb_sub_address (sccb_sub_address),
    .sccb_data        (sccb_data),
    .config_busy      (config_busy),
    .config_done      (config_done),
    .config_error     (config_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: the documented init table and the rules for walking it
  logic [15:0] table_ref [8] = '{16'h1280, 16'hFFF0, 16'h1104, 16'h1204,
                                 16'h40D0, 16'h3A04, 16'h8C00, 16'hFFFF};
  logic [15:0] exp_wr[$];
  int          exp_delay_wr;

  task automatic build_model();
    logic [15:0] e;
    exp_wr.delete();
    exp_delay_wr = -1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      e = (i < 8) ? table_ref[i] : 16'hFFFF;
      if (e == 16'hFFFF) break;
      if (e == 16'hFFF0) exp_delay_wr = exp_wr.size();
      else exp_wr.push_back(e);
    end
  endtask

  // SCCB responder and bus monitor
  int          ready_hold = 0;
  bit          no_done = 0;
  int          done_lat = 20;
  int          rsp_ph = 0;
  int          rsp_cnt = 0;
  bit          prev_start = 0;
  logic [15:0] cur_wr = 16'h0;
  logic [15:0] obs_wr[$];
  int          start_cyc[$];
  int          done_cyc[$];
  int          acc_cyc[$];
  int          stab_err = 0;
  int          hold_err = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sccb_ready = 1'b0;
      sccb_done  = 1'b0;
      rsp_ph     = 0;
      prev_start = 0;
    end else begin
      if (sccb_start && !prev_start) begin
        cur_wr = {sccb_sub_address, sccb_data};
        obs_wr.push_back(cur_wr);
        start_cyc.push_back(cyc);
      end
      if ((sccb_start || rsp_ph != 0) && {sccb_sub_address, sccb_data} !== cur_wr) stab_err++;
      prev_start = sccb_start;
      case (rsp_ph)
        0: begin
          if (ready_hold > 0) begin
            if (sccb_start) hold_err++;
            sccb_ready = 1'b0;
            ready_hold--;
          end else if (sccb_start && sccb_ready) begin
            sccb_ready = 1'b0;
            acc_cyc.push_back(cyc);
            rsp_cnt = done_lat;
            rsp_ph  = 1;
          end else begin
            sccb_ready = 1'b1;
          end
        end
        1: begin
          if (rsp_cnt > 1) rsp_cnt--;
          else if (!no_done) begin
            sccb_done = 1'b1;
            done_cyc.push_back(cyc);
            rsp_ph = 2;
          end
        end
        default: begin
          sccb_done  = 1'b0;
          sccb_ready = 1'b1;
          rsp_ph     = 0;
        end
      endcase
    end
  end

  task automatic clear_logs();
    obs_wr.delete();
    start_cyc.delete();
    done_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic kick();
    config_start = 1'b1;
    @(negedge clk);
    config_start = 1'b0;
  endtask

  task automatic wait_end(input int bound, input bit inject, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (config_done || config_error) begin
        ok = 1;
        break;
      end
      config_start = inject && config_busy && ($urandom_range(0, 15) == 0);
    end
    config_start = 1'b0;
  endtask

  function automatic bit seq_matches();
    if (obs_wr.size() != exp_wr.size()) return 0;
    foreach (exp_wr[i]) if (obs_wr[i] !== exp_wr[i]) return 0;
    return 1;
  endfunction

  initial begin
    bit ok;
    int kick_cyc;
    int err_cyc;
    int j;
    bit gap_ok;

    build_model();
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {sccb_start, sccb_sub_address, sccb_data,
                               config_busy, config_done, config_error}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: ready held low after start, config_start pulsed while busy
    clear_logs();
    done_lat   = 20;
    ready_hold = 30;
    kick_cyc   = cyc;
    kick();
    wait_end(4000, 1, ok);
    check_eq("run1_finished", ok, 1);
    check_eq("run1_flags", {config_done, config_busy, config_error}, 3'b100);
    check_eq("run1_nwr", obs_wr.size(), exp_wr.size());
    foreach (exp_wr[i])
      check_eq($sformatf("run1_wr%0d", i), (i < obs_wr.size()) ? obs_wr[i] : 16'hxxxx, exp_wr[i]);
    check_eq("run1_start_while_not_ready", hold_err, 0);
    check_eq("run1_addr_data_stable", stab_err, 0);
    check_eq("run1_hold_respected", (start_cyc.size() > 0) && (start_cyc[0] >= kick_cyc + 30), 1);
    j = exp_delay_wr;
    gap_ok = (j > 0) && (start_cyc.size() > j) && (done_cyc.size() >= j) &&
             (start_cyc[j] - done_cyc[j-1] > DLY);
    check_eq("run1_delay_gap", gap_ok, 1);

    // Randomized runs
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      done_lat   = $urandom_range(1, 30);
      ready_hold = $urandom_range(0, 10);
      kick();
      wait_end(4000, 1, ok);
      check_eq($sformatf("rand%0d_flags", r), {ok, config_done, config_busy, config_error}, 4'b1100);
      check_eq($sformatf("rand%0d_nwr", r), obs_wr.size(), exp_wr.size());
      check_eq($sformatf("rand%0d_sequence", r), seq_matches(), 1);
    end

    // Timeout: the responder accepts but never reports done
    clear_logs();
    no_done  = 1;
    done_lat = 5;
    kick();
    wait_end(1000, 0, ok);
    err_cyc = cyc;
    check_eq("tmo_seen", ok, 1);
    check_eq("tmo_flags", {config_done, config_busy, config_error}, 3'b001);
    check_eq("tmo_start_low", sccb_start, 0);
    check_eq("tmo_cycle", err_cyc, (acc_cyc.size() > 0) ? acc_cyc[0] + 1 + TMO : -1);
    check_eq("tmo_first_wr", (obs_wr.size() > 0) ? obs_wr[0] : 16'hxxxx, exp_wr[0]);
    no_done = 0;
    repeat (40) @(negedge clk);
    check_eq("stray_done_ignored", {sccb_start, config_busy, config_done, config_error}, 4'b0001);

    // Reset during WAIT_DONE, then replay from the start of the table
    clear_logs();
    done_lat = 20;
    kick();
    for (int i = 0; i < 300 && acc_cyc.size() == 0; i++) @(negedge clk);
    check_eq("rst_accept_seen", acc_cyc.size() > 0, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("rst_async_outputs", {sccb_start, sccb_sub_address, sccb_data,
                                      config_busy, config_done, config_error}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("rst_no_restart", {sccb_start, config_busy, config_done}, 3'b000);
    clear_logs();
    kick();
    wait_end(4000, 0, ok);
    check_eq("rst_replay_flags", {ok, config_done, config_busy, config_error}, 4'b1100);
    check_eq("rst_replay_nwr", obs_wr.size(), exp_wr.size());
    check_eq("rst_replay_first", (obs_wr.size() > 0) ? obs_wr[0] : 16'hxxxx, exp_wr[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ov7670_config.md
OV7670_CONFIG -- requirements
Module: ov7670_config

Interface
REQ-001 Parameter DELAY_CYCLES, default 100000; clk cycles waited per delay entry (1 ms at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000; maximum clk cycles allowed in WAIT_ACCEPT or WAIT_DONE.
REQ-003 Parameter ROM_DEPTH, default 256; number of table entries; index width is clog2(ROM_DEPTH).
REQ-004 Ports SHALL be exactly:
  - clk  input  1  single clock, rising edge.
  - rst_n  input  1  reset, asynchronous assert, active-low.
  - config_start  input  1  one-cycle request to (re)run the table.
  - sccb_ready  input  1  SCCB idle and able to accept a write.
  - sccb_done  input  1  SCCB one-cycle pulse: 3-phase write finished.
  - sccb_start  output  1  write request to SCCB.
  - sccb_sub_address  output  8  OV7670 register address.
  - sccb_data  output  8  OV7670 register value.
  - config_busy  output  1  sequence in progress.
  - config_done  output  1  sequence completed without error (sticky).
  - config_error  output  1  SCCB timeout occurred (sticky).

Function
REQ-005 Table entries SHALL be 16 bits, {address[15:8], value[7:0]}, read from the ROM at the current index.
REQ-006 Entry 16'hFFFF SHALL be the end marker; entry 16'hFFF0 SHALL be a delay marker; all other entries are register writes.
REQ-007 States: IDLE, FETCH, WAIT_READY, WAIT_ACCEPT, WAIT_DONE, DELAY, FINISH.
REQ-008 IDLE -> FETCH on config_start=1; this clears the index, config_done and config_error, and sets config_busy=1.
REQ-009 FETCH (1 cycle, ROM read latency 1): end marker -> FINISH; delay marker -> DELAY; otherwise latch address and value onto sccb_sub_address/sccb_data -> WAIT_READY.
REQ-010 WAIT_READY: when sccb_ready=1, assert sccb_start -> WAIT_ACCEPT.
REQ-011 WAIT_ACCEPT: hold sccb_start=1 until sccb_ready=0, then deassert sccb_start -> WAIT_DONE.
REQ-012 sccb_sub_address and sccb_data SHALL stay stable from FETCH until exit from WAIT_DONE.
REQ-013 WAIT_DONE: on sccb_done=1, increment the index -> FETCH.
REQ-014 A sccb_done pulse seen in any other state SHALL be ignored.
REQ-015 DELAY: count DELAY_CYCLES cycles, then increment the index -> FETCH.
REQ-016 Index reaching ROM_DEPTH-1 without an end marker SHALL be treated as the end marker (no wrap-around).
REQ-017 FINISH (1 cycle): config_busy=0, config_done=1 -> IDLE.
REQ-018 Timeout: the counter resets on entry to WAIT_ACCEPT or WAIT_DONE. If it reaches TIMEOUT_CYCLES:
  - sccb_start=0, config_error=1, config_busy=0, config_done stays 0;
  - next state is IDLE.
REQ-019 config_start while config_busy=1 SHALL be ignored.
REQ-020 sccb_start SHALL be registered and glitch-free; only asserted in WAIT_READY→WAIT_ACCEPT and WAIT_ACCEPT.

Reset
REQ-021 rst_n=0 SHALL immediately force:
  - state IDLE, index 0, all counters 0;
  - sccb_start=0, sccb_sub_address=8'h00, sccb_data=8'h00;
  - config_busy=0, config_done=0, config_error=0.
REQ-022 Reset asserted mid-write SHALL abort the sequence; no auto-restart, a new config_start is required.

Structure
REQ-023 Package ov7670_pkg SHALL hold:
  - the state enum;
  - END_MARKER=16'hFFFF and DELAY_MARKER=16'hFFF0;
  - the OV7670 reset entry 16'h1280.
REQ-024 Sub-module ov7670_config_rom SHALL hold the table as a synchronous-read case ROM (address in, 16-bit entry out, 1-cycle latency).
REQ-025 The ROM's first entry SHALL be 16'h1280 followed by DELAY_MARKER; its final entry SHALL be END_MARKER.

Verification
REQ-026 Test ROM {16'h12AA... → use 16'hAA77, 16'hFFFF}, SCCB model ready=1, done 20 cycles after accept:
  - one write with address 8'hAA, data 8'h77;
  - then config_done=1, config_busy=0.
REQ-027 Table {1280, FFF0, 1104, FFFF}, DELAY_CYCLES=50: the second write's sccb_start rises no earlier than 50 cycles after the first write's sccb_done.
REQ-028 sccb_ready held 0 for 30 cycles after FETCH: sccb_start stays 0 throughout; the write proceeds once ready=1.
REQ-029 TIMEOUT_CYCLES=100, model never pulses done: config_error=1 and sccb_start=0 at cycle 100 after accept; config_done=0.
REQ-030 rst_n pulled low during WAIT_DONE:
  - all outputs return to reset values within the same cycle;
  - a new config_start replays the table from index 0.
REQ-031 config_start pulsed while busy: sequence unaffected, write count equals the number of table entries.
